i_o_input_controller: RTL and testbench
=======================================

# i_o_input_controller

UART receiver for the I/O subsystem: it deserialises the host's serial line into bytes for the CPU-side I/O logic. It is the receive-direction counterpart of the output controller, sharing the same 8N1 framing with LSB first, start bit 0 and stop bit 1. Bit timing comes from an external oversampling strobe. A one-byte holding register with a ready/ack handshake sits between the deserialiser and the consumer.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `active` strobes per bit period. Must be even and ≥4.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `TXD` input 1: serial line from the host. It is asynchronous to `clk` and idles high.
- `active` input 1: one-`clk` strobe at `OVERSAMPLE` × baud. All bit timing advances only on cycles where it is high.
- `io_input_value` output 8: the held byte. Valid while `io_input_ready_trigger` is 1.
- `io_input_ready_trigger` output 1: 1 while the holding register holds an unconsumed byte.
- `io_input_ack_trigger` input 1: one-`clk` pulse from the consumer. It frees the holding register.
- `io_input_frame_error` output 1: one-`clk` pulse when a frame's stop bit samples 0.
- `io_input_overrun` output 1: one-`clk` pulse when a completed byte is dropped because the holding register is full.

## Operation
- `TXD` passes through a 2-FF synchroniser (reset value 1) giving `line`. A third register `line_prev` (reset 1) holds the previous `line` value sampled on an `active` cycle.
- The state machine has four states: `IN_IDLE`, `IN_START`, `IN_DATA`, `IN_STOP`. Registers: tick counter `tick_cnt` [$clog2(OVERSAMPLE)-1:0], bit counter `bit_cnt` [2:0], shift register `shift` [7:0].
- `IN_IDLE`: on an `active` cycle with `line`=0 and `line_prev`=1 (falling edge), clear `tick_cnt` and go to `IN_START`. A line held low never retriggers.
- `IN_START`: `tick_cnt` increments on each `active`. When `tick_cnt` reaches OVERSAMPLE/2−1 (mid-bit):
  - if `line`=0, clear `tick_cnt` and `bit_cnt`, go to `IN_DATA`;
  - otherwise it is a false start: go to `IN_IDLE` with no outputs.
- `IN_DATA`: `tick_cnt` increments on each `active` and wraps at OVERSAMPLE−1. At OVERSAMPLE−1:
  - shift in, with `shift` <= {`line`, `shift`[7:1]};
  - `bit_cnt`++;
  - after the 8th bit (`bit_cnt`==7), go to `IN_STOP`.
- `IN_STOP`: at `tick_cnt`==OVERSAMPLE−1, sample `line`.
  - 1: deliver `shift` to the holding register (rules below), then go to `IN_IDLE`.
  - 0: pulse `io_input_frame_error`, discard the byte, go to `IN_IDLE`.
- Holding register, on a delivery cycle:
  - if empty, or `io_input_ack_trigger`=1 in the same cycle: load `io_input_value`, set ready to 1;
  - else: keep the old byte and pulse `io_input_overrun`.
- `io_input_ack_trigger` with no delivery in the same cycle clears ready. When not ready it is ignored.
- `io_input_value` holds its last value after ack. It does not change except on a load.

## Timing
- Reset values: `io_input_value`=0x00, `io_input_ready_trigger`=0, `io_input_frame_error`=0, `io_input_overrun`=0, state `IN_IDLE`, counters 0, `shift`=0.
- Reset mid-frame aborts the frame immediately. The first byte after release needs a fresh falling edge.
- Synchroniser latency: 2 `clk`. Edge-detect resolution: 1 `active` period.
- Data sampling: the start bit is sampled OVERSAMPLE/2 ticks after the edge. Each subsequent sample is OVERSAMPLE ticks later, i.e. at mid-bit.
- `io_input_ready_trigger` rises on the `clk` edge of the stop-bit sampling cycle. The flag pulses occur on that same edge.
- Ack-to-ready-low latency: 1 `clk`. Back-to-back frames need no idle gap beyond the stop bit.

## Structure
- Shared package `i_o_pkg` holds:
  - `typedef enum logic [1:0] INPUT_CONTROLLER_STATE {IN_IDLE, IN_START, IN_DATA, IN_STOP}`;
  - the frame constants `IO_DATA_BITS=8`, `IO_START_LEVEL=0`, `IO_STOP_LEVEL=1`.
- Sub-module `i_o_sync2`: a generic 2-FF synchroniser with a reset-value parameter. It is reused by other asynchronous inputs.

## Test plan
- OVERSAMPLE=16, `active` every 4 `clk`, send 0xA5 → `io_input_value`=0xA5, `io_input_ready_trigger`=1, no flags. Ack → ready 0 one `clk` later.
- Low glitch of 4 ticks (shorter than half a bit), then line high → no ready, no flags, FSM back in `IN_IDLE`.
- Send 0x3C with the stop bit forced to 0 → one-cycle `io_input_frame_error`, ready stays 0. A following valid 0x11 is received correctly.
- Send 0x01 then 0x02 with no ack → `io_input_overrun` pulses at the second stop bit, value stays 0x01.
- Ack coincident with completion of the second byte 0x7E → value 0x7E, ready stays 1, no overrun.
- Assert `rst_n`=0 during data bit 4 of 0xFF → all outputs at reset values. After release, 0x55 is received correctly.

Source files
------------

// File: rtl/i_o_pkg.sv
// Shared I/O subsystem definitions: receive FSM states and 8N1 frame constants.
package i_o_pkg;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_START,
    IN_DATA,
    IN_STOP
  } INPUT_CONTROLLER_STATE;

  localparam int unsigned IO_DATA_BITS   = 8;
  localparam logic        IO_START_LEVEL = 1'b0;
  localparam logic        IO_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/i_o_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs.
module i_o_sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i_o_input_controller.sv
// UART receiver (8N1, LSB first) with a one-byte ready/ack holding register.
module i_o_input_controller
  import i_o_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    TXD,
  input  logic                    active,
  output logic [IO_DATA_BITS-1:0] io_input_value,
  output logic                    io_input_ready_trigger,
  input  logic                    io_input_ack_trigger,
  output logic                    io_input_frame_error,
  output logic                    io_input_overrun
);

  localparam int unsigned    TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(IO_DATA_BITS - 1);

  INPUT_CONTROLLER_STATE     state, state_d;
  logic [TW-1:0]             tick_cnt, tick_d;
  logic [2:0]                bit_cnt, bit_d;
  logic [IO_DATA_BITS-1:0]   shift, shift_d;
  logic                      line, line_prev;
  logic                      deliver, frame_bad;

  i_o_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (TXD),
    .q     (line)
  );

  // Previous synchronised line level, advanced only on oversampling ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_prev <= 1'b1;
    else if (active) line_prev <= line;
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IN_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
    end
  end

  // Next-state, tick/bit counting, shifting and stop-bit outcome.
  always_comb begin
    state_d   = state;
    tick_d    = tick_cnt;
    bit_d     = bit_cnt;
    shift_d   = shift;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IN_IDLE: begin
        if (active && line == IO_START_LEVEL && line_prev != IO_START_LEVEL) begin
          tick_d  = '0;
          state_d = IN_START;
        end
      end
      IN_START: begin
        if (active) begin
          if (tick_cnt == TICK_HALF) begin
            if (line == IO_START_LEVEL) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = IN_DATA;
            end else begin
              state_d = IN_IDLE;
            end
          end else begin
            tick_d = tick_cnt + TW'(1);
          end
        end
      end
      IN_DATA: begin
        if (active) begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {line, shift[IO_DATA_BITS-1:1]};
            bit_d   = bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) state_d = IN_STOP;
          end else begin
            tick_d = tick_cnt + TW'(1);
          end
        end
      end
      IN_STOP: begin
        if (active) begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            state_d = IN_IDLE;
            if (line == IO_STOP_LEVEL) deliver = 1'b1;
            else frame_bad = 1'b1;
          end else begin
            tick_d = tick_cnt + TW'(1);
          end
        end
      end
      default: state_d = IN_IDLE;
    endcase
  end

  // Holding register with ready/ack handshake and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_input_value         <= '0;
      io_input_ready_trigger <= 1'b0;
      io_input_frame_error   <= 1'b0;
      io_input_overrun       <= 1'b0;
    end else begin
      io_input_frame_error <= frame_bad;
      io_input_overrun     <= deliver && io_input_ready_trigger && !io_input_ack_trigger;
      if (deliver && (!io_input_ready_trigger || io_input_ack_trigger)) begin
        io_input_value         <= shift;
        io_input_ready_trigger <= 1'b1;
      end else if (io_input_ack_trigger && !deliver) begin
        io_input_ready_trigger <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i_o_input_controller.sv
// Scoreboard bench for the UART receiver: bytes are queued when sent and
// popped when the holding register loads.
module tb_i_o_input_controller;
  import i_o_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       TXD = 1'b1;
  logic       active = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] value;
  logic       ready, frame_error, overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] sb_q[$];
  logic       ready_q = 1'b0;
  logic [7:0] value_q = 8'h00;

  i_o_input_controller #(.OVERSAMPLE(16)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .TXD                    (TXD),
    .active                 (active),
    .io_input_value         (value),
    .io_input_ready_trigger (ready),
    .io_input_ack_trigger   (ack),
    .io_input_frame_error   (frame_error),
    .io_input_overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One active strobe every 4 clk.
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      active = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Monitor: count status pulses, compare each holding-register load.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ferr_cnt += int'(frame_error);
        ovr_cnt  += int'(overrun);
        if (ready && (!ready_q || value != value_q)) begin
          chk("rx_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) chk("rx_byte", 32'(value), 32'(sb_q.pop_front()));
        end
      end
      ready_q = ready;
      value_q = value;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_active();
    do @(posedge clk); while (!active);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    hold(1);
    ack = 1'b0;
  endtask

  // mode 0: plain; 1: ack coincident with stop sample; 2: check ready timing
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    sync_active();
    TXD = 1'b0;
    hold(64);
    for (int i = 0; i < 8; i++) begin
      TXD = b[i];
      hold(64);
    end
    TXD = stop;
    if (mode == 0) begin
      hold(64);
    end else begin
      hold(35);
      if (mode == 2) chk("ready_before_stop", 32'(ready), 32'd0);
      if (mode == 1) ack = 1'b1;
      hold(1);
      ack = 1'b0;
      if (mode == 2) chk("ready_at_stop", 32'(ready), 32'd1);
      hold(28);
    end
  endtask

  initial begin
    hold(10);
    chk("rst_value", 32'(value), 32'h00);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IN_IDLE));
    rst_n = 1'b1;
    hold(10);

    // Basic byte and ack latency
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 2);
    hold(8);
    chk("a5_value", 32'(value), 32'hA5);
    chk("a5_ready", 32'(ready), 32'd1);
    chk("a5_flags", 32'(ferr_cnt + ovr_cnt), 32'd0);
    ack_pulse();
    chk("ack_ready_low", 32'(ready), 32'd0);
    chk("ack_value_hold", 32'(value), 32'hA5);

    // Short low glitch is a false start
    sync_active();
    TXD = 1'b0;
    hold(16);
    TXD = 1'b1;
    hold(80);
    chk("glitch_ready", 32'(ready), 32'd0);
    chk("glitch_flags", 32'(ferr_cnt + ovr_cnt), 32'd0);
    chk("glitch_state", 32'(dut.state), 32'(IN_IDLE));

    // Framing error then recovery
    send_frame(8'h3C, 1'b0, 0);
    TXD = 1'b1;
    hold(64);
    chk("ferr_count", 32'(ferr_cnt), 32'd1);
    chk("ferr_ready", 32'(ready), 32'd0);
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0);
    hold(4);
    chk("after_ferr_value", 32'(value), 32'h11);
    chk("after_ferr_ready", 32'(ready), 32'd1);
    ack_pulse();

    // Overrun: second byte dropped
    sb_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    hold(4);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    chk("ovr_value", 32'(value), 32'h01);
    chk("ovr_ready", 32'(ready), 32'd1);

    // Ack coincident with delivery
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1);
    hold(4);
    chk("coinc_value", 32'(value), 32'h7E);
    chk("coinc_ready", 32'(ready), 32'd1);
    chk("coinc_no_ovr", 32'(ovr_cnt), 32'd1);

    // Reset during data bit 4 of 0xFF
    sync_active();
    TXD = 1'b0;
    hold(64);
    TXD = 1'b1;
    hold(64 * 4 + 32);
    rst_n = 1'b0;
    hold(2);
    chk("mid_rst_value", 32'(value), 32'h00);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_flags", 32'({frame_error, overrun}), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IN_IDLE));
    hold(20);
    rst_n = 1'b1;
    hold(64 * 5);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 0);
    hold(4);
    chk("post_rst_value", 32'(value), 32'h55);
    chk("post_rst_ready", 32'(ready), 32'd1);
    ack_pulse();

    hold(8);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("final_ferr", 32'(ferr_cnt), 32'd1);
    chk("final_ovr", 32'(ovr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
